// File: rtl/uart_rx_param.sv
`default_nettype none
// ==========================================================================
// uart_rx_param : oversampling UART receiver, 2-of-3 majority bit voting,
// optional parity, 1/2 stop bits, single-entry hold register.  Rev 1.0
// ==========================================================================
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_in,
   input  logic                 char_ack,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 charReceived,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] SMP_LO    = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] SMP_MID   = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] SMP_HI    = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PAR       = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   logic                 sync1_q, sync1_d;
   logic                 rx_q, rx_d;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [1:0]           smp_q, smp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_acc_q, par_acc_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 char_rcvd_q, char_rcvd_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic                 vote;
   logic                 bit_end;
   logic                 decide;
   logic                 frame_done;
   logic                 done_ferr;

   always_comb begin
      sync1_d     = data_in;
      rx_d        = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      smp_d       = smp_q;
      shift_d     = shift_q;
      par_acc_d   = par_acc_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      frame_done  = 1'b0;
      done_ferr   = 1'b0;
      vote        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_q) | (smp_q[1] & rx_q);
      bit_end     = (cnt_q == CNT_LAST);
      decide      = (cnt_q == SMP_HI);

      if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q == SMP_LO)  smp_d[0] = rx_q;
         if (cnt_q == SMP_MID) smp_d[1] = rx_q;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_q) begin
               state_d   = S_START;
               par_acc_d = 1'b0;
               perr_d    = 1'b0;
               ferr_d    = 1'b0;
            end
         end
         S_START: begin
            // A start bit that votes high was noise; drop it mid-bit.
            if (decide && vote) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (decide) begin
               shift_d   = {vote, shift_q[DATA_BITS-1:1]};
               par_acc_d = par_acc_q ^ vote;
            end
            if (bit_end) begin
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_PAR: begin
            if (decide) perr_d = (PARITY == 2) ? ~(par_acc_q ^ vote) : (par_acc_q ^ vote);
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (decide) begin
               ferr_d = ferr_q | ~vote;
               if (idx_q == STOP_LAST) begin
                  frame_done = 1'b1;
                  done_ferr  = ferr_q | ~vote;
                  state_d    = done_ferr ? S_WAIT_IDLE : S_IDLE;
                  cnt_d      = '0;
                  idx_d      = '0;
               end
            end
            if (bit_end) idx_d = idx_q + IDX_W'(1);
         end
         S_WAIT_IDLE: begin
            cnt_d = '0;
            if (rx_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      data_out_d   = data_out_q;
      char_rcvd_d  = char_rcvd_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      if (char_rcvd_q && char_ack) char_rcvd_d = 1'b0;
      // An unacknowledged held character wins; the new one is dropped.
      if (frame_done) begin
         if (char_rcvd_q && !char_ack) begin
            overrun_d = 1'b1;
         end else begin
            data_out_d   = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = done_ferr;
            char_rcvd_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         rx_q         <= 1'b1;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         smp_q        <= '0;
         shift_q      <= '0;
         par_acc_q    <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         data_out_q   <= '0;
         char_rcvd_q  <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         rx_q         <= rx_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         smp_q        <= smp_d;
         shift_q      <= shift_d;
         par_acc_q    <= par_acc_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         data_out_q   <= data_out_d;
         char_rcvd_q  <= char_rcvd_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out     = data_out_q;
   assign charReceived = char_rcvd_q;
   assign parity_err   = parity_err_q;
   assign frame_err    = frame_err_q;
   assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ==========================================================================
// tb_uart_rx_param : randomized frames on four receiver configurations,
// checked against expected characters built from the frame contents. Rev 1.0
// ==========================================================================
module tb_uart_rx_param;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] din;
   logic [3:0] ack;

   logic [7:0] dout_def, dout_evn, dout_odd;
   logic [8:0] dout_9b;
   logic cr_def, pe_def, fe_def, ov_def;
   logic cr_evn, pe_evn, fe_evn, ov_evn;
   logic cr_odd, pe_odd, fe_odd, ov_odd;
   logic cr_9b,  pe_9b,  fe_9b,  ov_9b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_def (
      .clk(clk), .reset(reset), .data_in(din[0]), .char_ack(ack[0]), .data_out(dout_def),
      .charReceived(cr_def), .parity_err(pe_def), .frame_err(fe_def), .overrun(ov_def));
   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_evn (
      .clk(clk), .reset(reset), .data_in(din[1]), .char_ack(ack[1]), .data_out(dout_evn),
      .charReceived(cr_evn), .parity_err(pe_evn), .frame_err(fe_evn), .overrun(ov_evn));
   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_odd (
      .clk(clk), .reset(reset), .data_in(din[2]), .char_ack(ack[2]), .data_out(dout_odd),
      .charReceived(cr_odd), .parity_err(pe_odd), .frame_err(fe_odd), .overrun(ov_odd));
   uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2)) u_9b (
      .clk(clk), .reset(reset), .data_in(din[3]), .char_ack(ack[3]), .data_out(dout_9b),
      .charReceived(cr_9b), .parity_err(pe_9b), .frame_err(fe_9b), .overrun(ov_9b));

   // Drives one frame, one line value per negedge; index m counts from the
   // leading edge of the start bit. stop_at truncates the frame.
   task automatic send(input int sel, input int os, input logic [8:0] data, input int nbits,
                       input bit has_par, input logic pbit, input logic [1:0] stops,
                       input int nstop, input int glitch_idx, input int ack_idx,
                       input int stop_at);
      logic bits[$];
      int   n;
      bits.push_back(1'b0);
      for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
      if (has_par) bits.push_back(pbit);
      for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
      n = (stop_at >= 0) ? stop_at : bits.size() * os;
      for (int m = 0; m < n; m++) begin
         @(negedge clk);
         din[sel] = (m == glitch_idx) ? ~bits[m / os] : bits[m / os];
         ack[sel] = (m == ack_idx);
      end
   endtask

   task automatic idle(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         din[sel] = 1'b1;
         ack[sel] = 1'b0;
      end
   endtask

   task automatic pulse_ack(input int sel);
      @(negedge clk);
      din[sel] = 1'b1;
      ack[sel] = 1'b1;
      @(negedge clk);
      ack[sel] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      din   = 4'hF;
      ack   = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dout_def, cr_def, pe_def, fe_def, ov_def} !== 12'h000) begin
         errors++; $display("FAIL reset_def: got %h required 000", {dout_def, cr_def, pe_def, fe_def, ov_def});
      end
      checks++;
      if ({dout_evn, cr_evn, pe_evn, fe_evn, ov_evn} !== 12'h000) begin
         errors++; $display("FAIL reset_evn: got %h required 000", {dout_evn, cr_evn, pe_evn, fe_evn, ov_evn});
      end
      checks++;
      if ({dout_odd, cr_odd, pe_odd, fe_odd, ov_odd} !== 12'h000) begin
         errors++; $display("FAIL reset_odd: got %h required 000", {dout_odd, cr_odd, pe_odd, fe_odd, ov_odd});
      end
      checks++;
      if ({dout_9b, cr_9b, pe_9b, fe_9b, ov_9b} !== 13'h0000) begin
         errors++; $display("FAIL reset_9b: got %h required 0000", {dout_9b, cr_9b, pe_9b, fe_9b, ov_9b});
      end
      reset = 1'b0;
      idle(0, 4);
   endtask

   // 0x55 8N1: stop decision lands on index 156, so the character shows at 157.
   task automatic test_frame_55();
      send(0, 16, 9'h055, 8, 1'b0, 1'b0, 2'b11, 1, -1, -1, 157);
      checks++;
      if (cr_def !== 1'b0) begin
         errors++; $display("FAIL f55_early: charReceived=%b required 0", cr_def);
      end
      @(negedge clk);
      checks++;
      if ({cr_def, dout_def, pe_def, fe_def, ov_def} !== {1'b1, 8'h55, 3'b000}) begin
         errors++; $display("FAIL f55_char: cr=%b data=%h pe=%b fe=%b ov=%b required 1 55 0 0 0",
                            cr_def, dout_def, pe_def, fe_def, ov_def);
      end
      idle(0, 4);
      pulse_ack(0);
      checks++;
      if (cr_def !== 1'b0) begin
         errors++; $display("FAIL f55_ack: charReceived=%b required 0", cr_def);
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       stop_ok;
      for (int it = 0; it < 8; it++) begin
         d       = 8'($urandom_range(0, 255));
         stop_ok = ($urandom_range(0, 3) != 0);
         send(0, 16, {1'b0, d}, 8, 1'b0, 1'b0, {1'b1, stop_ok}, 1, -1, -1, -1);
         idle(0, 3);
         checks++;
         if ({cr_def, dout_def, pe_def, fe_def, ov_def} !== {1'b1, d, 1'b0, ~stop_ok, 1'b0}) begin
            errors++; $display("FAIL rand_%0d: cr=%b data=%h pe=%b fe=%b ov=%b required 1 %h 0 %b 0",
                               it, cr_def, dout_def, pe_def, fe_def, ov_def, d, ~stop_ok);
         end
         pulse_ack(0);
         checks++;
         if (cr_def !== 1'b0) begin
            errors++; $display("FAIL rand_ack_%0d: charReceived=%b required 0", it, cr_def);
         end
         idle(0, $urandom_range(2, 20));
      end
   endtask

   task automatic test_false_start_glitch();
      logic [7:0] d;
      int         b;
      for (int it = 0; it < 2; it++) begin
         d = (it == 0) ? 8'h5A : 8'($urandom_range(0, 255));
         b = (it == 0) ? 2 : int'($urandom_range(0, 7));
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din[0] = 1'b0;
         end
         idle(0, 6);
         // Real start right after the false one, glitch on the centre sample.
         send(0, 16, {1'b0, d}, 8, 1'b0, 1'b0, 2'b11, 1, 16 * (b + 1) + 9, -1, 157);
         checks++;
         if (cr_def !== 1'b0) begin
            errors++; $display("FAIL false_start_%0d: charReceived=%b required 0", it, cr_def);
         end
         @(negedge clk);
         checks++;
         if ({cr_def, dout_def, fe_def} !== {1'b1, d, 1'b0}) begin
            errors++; $display("FAIL glitch_%0d: cr=%b data=%h fe=%b required 1 %h 0",
                               it, cr_def, dout_def, fe_def, d);
         end
         idle(0, 4);
         pulse_ack(0);
         idle(0, 5);
      end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      logic       p;
      logic       ones;
      for (int it = 0; it < 5; it++) begin
         d    = (it == 0) ? 8'h07 : 8'($urandom_range(0, 255));
         p    = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         ones = ^d ^ p;
         send(1, 16, {1'b0, d}, 8, 1'b1, p, 2'b11, 1, -1, -1, -1);
         idle(1, 3);
         checks++;
         if ({cr_evn, dout_evn, pe_evn, fe_evn} !== {1'b1, d, ones, 1'b0}) begin
            errors++; $display("FAIL par_even_%0d: cr=%b data=%h pe=%b fe=%b required 1 %h %b 0",
                               it, cr_evn, dout_evn, pe_evn, fe_evn, d, ones);
         end
         pulse_ack(1);
         send(2, 16, {1'b0, d}, 8, 1'b1, p, 2'b11, 1, -1, -1, -1);
         idle(2, 3);
         checks++;
         if ({cr_odd, dout_odd, pe_odd, fe_odd} !== {1'b1, d, ~ones, 1'b0}) begin
            errors++; $display("FAIL par_odd_%0d: cr=%b data=%h pe=%b fe=%b required 1 %h %b 0",
                               it, cr_odd, dout_odd, pe_odd, fe_odd, d, ~ones);
         end
         pulse_ack(2);
      end
   endtask

   task automatic test_break();
      for (int m = 0; m < 300; m++) begin
         @(negedge clk);
         if (m == 200) begin
            checks++;
            if ({cr_def, dout_def, pe_def, fe_def, ov_def} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b0}) begin
               errors++; $display("FAIL break_char: cr=%b data=%h pe=%b fe=%b ov=%b required 1 00 0 1 0",
                                  cr_def, dout_def, pe_def, fe_def, ov_def);
            end
         end
         if (m == 299) begin
            checks++;
            if ({cr_def, ov_def} !== 2'b00) begin
               errors++; $display("FAIL break_single: cr=%b ov=%b required 0 0", cr_def, ov_def);
            end
         end
         din[0] = 1'b0;
         ack[0] = (m == 250);
      end
      idle(0, 5);
      send(0, 16, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1, -1, -1, -1);
      idle(0, 3);
      checks++;
      if ({cr_def, dout_def, fe_def, ov_def} !== {1'b1, 8'h3C, 2'b00}) begin
         errors++; $display("FAIL break_recover: cr=%b data=%h fe=%b ov=%b required 1 3c 0 0",
                            cr_def, dout_def, fe_def, ov_def);
      end
      pulse_ack(0);
   endtask

   task automatic test_back_to_back();
      send(0, 16, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, -1, -1, -1);
      send(0, 16, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, -1, -1, -1);
      idle(0, 3);
      checks++;
      if ({cr_def, dout_def, ov_def} !== {1'b1, 8'h11, 1'b1}) begin
         errors++; $display("FAIL b2b_overrun: cr=%b data=%h ov=%b required 1 11 1", cr_def, dout_def, ov_def);
      end
      pulse_ack(0);
      checks++;
      if ({cr_def, ov_def} !== 2'b01) begin
         errors++; $display("FAIL b2b_sticky: cr=%b ov=%b required 0 1", cr_def, ov_def);
      end
      do_reset();
      checks++;
      if (ov_def !== 1'b0) begin
         errors++; $display("FAIL b2b_reset: overrun=%b required 0", ov_def);
      end
      idle(0, 4);
      send(0, 16, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, -1, -1, -1);
      send(0, 16, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, -1, 156, 157);
      checks++;
      if ({cr_def, dout_def} !== {1'b1, 8'h11}) begin
         errors++; $display("FAIL b2b_hold: cr=%b data=%h required 1 11", cr_def, dout_def);
      end
      @(negedge clk);
      ack[0] = 1'b0;
      checks++;
      if ({cr_def, dout_def, ov_def} !== {1'b1, 8'h22, 1'b0}) begin
         errors++; $display("FAIL b2b_coincide: cr=%b data=%h ov=%b required 1 22 0", cr_def, dout_def, ov_def);
      end
      idle(0, 4);
      pulse_ack(0);
   endtask

   task automatic test_reset_abort();
      logic [8:0] d;
      send(3, 8, 9'h1A5, 9, 1'b0, 1'b0, 2'b11, 2, -1, -1, -1);
      idle(3, 3);
      checks++;
      if ({cr_9b, dout_9b, fe_9b} !== {1'b1, 9'h1A5, 1'b0}) begin
         errors++; $display("FAIL n9_first: cr=%b data=%h fe=%b required 1 1a5 0", cr_9b, dout_9b, fe_9b);
      end
      send(3, 8, 9'h055, 9, 1'b0, 1'b0, 2'b11, 2, -1, -1, -1);
      idle(3, 3);
      checks++;
      if ({dout_9b, ov_9b} !== {9'h1A5, 1'b1}) begin
         errors++; $display("FAIL n9_overrun: data=%h ov=%b required 1a5 1", dout_9b, ov_9b);
      end
      // Abort inside data bit 3.
      send(3, 8, 9'h0FF, 9, 1'b0, 1'b0, 2'b11, 2, -1, -1, 36);
      @(negedge clk);
      reset  = 1'b1;
      din[3] = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      checks++;
      if ({dout_9b, cr_9b, pe_9b, fe_9b, ov_9b} !== 13'h0000) begin
         errors++; $display("FAIL n9_abort: outputs=%h required 0000", {dout_9b, cr_9b, pe_9b, fe_9b, ov_9b});
      end
      idle(3, 100);
      checks++;
      if (cr_9b !== 1'b0) begin
         errors++; $display("FAIL n9_no_char: charReceived=%b required 0", cr_9b);
      end
      send(3, 8, 9'h0A3, 9, 1'b0, 1'b0, 2'b11, 2, -1, -1, -1);
      idle(3, 3);
      checks++;
      if ({cr_9b, dout_9b, fe_9b, ov_9b} !== {1'b1, 9'h0A3, 2'b00}) begin
         errors++; $display("FAIL n9_a3: cr=%b data=%h fe=%b ov=%b required 1 0a3 0 0",
                            cr_9b, dout_9b, fe_9b, ov_9b);
      end
      pulse_ack(3);
      d = 9'($urandom_range(0, 511));
      send(3, 8, d, 9, 1'b0, 1'b0, 2'b01, 2, -1, -1, -1);
      idle(3, 3);
      checks++;
      if ({cr_9b, dout_9b, fe_9b} !== {1'b1, d, 1'b1}) begin
         errors++; $display("FAIL n9_stop2: cr=%b data=%h fe=%b required 1 %h 1", cr_9b, dout_9b, fe_9b, d);
      end
      pulse_ack(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, required finish before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_frame_55();
      test_random();
      test_false_start_glitch();
      test_parity();
      test_break();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
